rv32_inst_loader: RTL and testbench
===================================

Name: rv32_inst_loader

Overview:
- Inverse of the opcode-to-control decode path: accepts RV32I instruction fields, encodes them into 32-bit instruction words, and writes them to instruction memory at consecutive word addresses.
- Supported classes are the four the single-cycle datapath executes: R-format, lw, sw and beq.
- Used to fill instruction memory before the core is released from reset, either by the bench or by a boot path.
- Provides a valid/ready input handshake, a session FSM, an address counter, immediate-range checking and a done/full status.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; depth is 2^ADDR_WIDTH.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  begins a load session; honoured only in IDLE or DONE
- in_valid  input  1  field bundle valid
- in_ready  output  1  loader can accept a bundle this cycle
- in_kind  input  2  00=R, 01=lw, 10=sw, 11=beq
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  R-format funct3; ignored for other kinds
- in_f7b5  input  1  R-format instr[30] (sub/sra); ignored otherwise
- in_imm  input  13  signed byte offset
- in_last  input  1  marks the final bundle of the session
- imem_we  output  1  write strobe, one cycle per word
- imem_addr  output  ADDR_WIDTH  word address
- imem_wdata  output  32  encoded instruction
- busy  output  1  state is LOAD, or a write is pending
- done  output  1  state is DONE
- full  output  1  session ended because the top address was written
- err_imm  output  1  sticky: at least one bundle was rejected
- count  output  ADDR_WIDTH+1  words written this session

Behaviour:
- Reset (rst=1 at a clk edge):
  - state←IDLE.
  - imem_we, imem_addr, imem_wdata, busy, done, full, err_imm and count all go to 0.
  - Any pending write is discarded.
  - Reset mid-session produces no further imem_we.
- States and transitions:
  - IDLE: start → LOAD; address←BASE_ADDR; count, err_imm and full cleared.
  - LOAD: accepts bundles.
    - The handshake carrying in_last → DONE after its write cycle.
    - Writing address 2^ADDR_WIDTH-1 → DONE with full=1, even without in_last.
  - DONE: done=1 and holds. start → LOAD, clearing as in IDLE. start in LOAD is ignored.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (state==LOAD) && no in_last accepted yet && top address not yet accepted.
  - in_ready does not depend on in_valid.
  - Throughput is one bundle per cycle.
- Latency:
  - An accepted bundle drives imem_we=1 with its imem_addr/imem_wdata exactly one cycle later, registered.
  - After the write, address increments by 1 and count increments by 1.
  - imem_we=0 in all other cycles.
- Encoding (funct3 forced for memory and branch kinds):
  - R: {0,f7b5,00000, rs2, rs1, funct3, rd, 0110011}.
  - lw: {imm[11:0], rs1, 010, rd, 0000011}.
  - sw: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - beq: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
- Immediate rules:
  - lw/sw: requires imm[12]==imm[11] (fits 12-bit signed).
  - beq: requires imm[0]==0.
  - R: imm ignored.
  - On violation: the bundle is consumed, no write occurs, address and count are unchanged, and err_imm←1 until the next start or rst.
  - A rejected bundle carrying in_last still ends the session.
- Simultaneous events:
  - rst has priority over everything.
  - Bundles whose handshake occurs in the same cycle as the previous bundle's write are both honoured in order.

Test Plan:
- rst, then start, then R bundle rd=3 rs1=1 rs2=2 funct3=0 f7b5=0 in_last=1 → one cycle later imem_we=1, addr=0, wdata=0x002081B3; next cycle done=1, count=1, in_ready=0.
- Back-to-back stream, in_valid held high: sub x3,x1,x2 / lw x5,8(x2) / sw x5,12(x2) / beq x1,x2,-4 (last) → four consecutive writes with addresses 0..3 and data 0x402081B3, 0x00812283, 0x00512623, 0xFE208EE3; count=4, done=1.
- Immediate rejection: lw with imm=2048, then beq with imm=3, then a valid add (last) → single write at addr 0, err_imm=1, count=1.
- Full: ADDR_WIDTH=2, five bundles offered, none marked last → writes to addresses 0..3, then in_ready=0; full=1, done=1; the fifth bundle is never accepted.
- Reset mid-session: assert rst in the cycle after a handshake → no imem_we in the following cycles, state IDLE, count=0, in_ready=0.
- Restart from DONE: pulse start → address back to BASE_ADDR, count=0, err_imm=0, in_ready=1 on the next cycle.

Source files
------------

// File: rtl/rv32_inst_loader.sv
// Purpose     : encodes RV32I field bundles (R, lw, sw, beq) into 32-bit words and
//               writes them to instruction memory at consecutive word addresses.
// Latency     : one cycle from an accepted bundle to its registered imem_we pulse.
// Backpressure: in_ready drops once the session's last bundle or the top address has
//               been accepted, and stays low outside LOAD; one bundle per cycle otherwise.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start                    opens a session from IDLE or DONE
//   in_valid / in_ready      field-bundle handshake
//   in_kind .. in_last       instruction fields, signed byte offset, end-of-session mark
//   imem_we/addr/wdata       registered instruction-memory write port
//   busy, done, full         session status
//   err_imm                  sticky: an out-of-range immediate was dropped this session
//   count                    words written this session
module rv32_inst_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_kind,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic                  in_f7b5,
  input  logic [12:0]           in_imm,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic                  err_imm,
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] TOP      = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   next_addr;   // address the next legal bundle will be written to
  logic                    last_seen;   // in_last already accepted this session
  logic                    top_seen;    // top address already accepted this session
  logic                    accept;
  logic                    start_session;
  logic                    imm_ok;
  logic [31:0]             enc;

  assign in_ready      = (state_q == LOAD) && !last_seen && !top_seen;
  assign accept        = in_valid && in_ready;
  assign start_session = start && ((state_q == IDLE) || (state_q == DONE));
  assign busy          = (state_q == LOAD) || imem_we;
  assign done          = (state_q == DONE);

  // Field encoder; memory and branch kinds force their own funct3.
  always_comb begin
    enc    = 32'd0;
    imm_ok = 1'b1;
    case (in_kind)
      2'b00: enc = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      2'b01: begin
        enc    = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        imm_ok = (in_imm[12] == in_imm[11]);
      end
      2'b10: begin
        enc    = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        imm_ok = (in_imm[12] == in_imm[11]);
      end
      default: begin
        enc    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                  in_imm[4:1], in_imm[11], 7'b1100011};
        imm_ok = !in_imm[0];
      end
    endcase
  end

  // The session closes one edge after the ending bundle is accepted, which is
  // also the edge that retires its write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (last_seen || top_seen) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      full       <= 1'b0;
      err_imm    <= 1'b0;
      count      <= '0;
      next_addr  <= BASE;
      last_seen  <= 1'b0;
      top_seen   <= 1'b0;
    end else begin
      state_q <= state_d;
      imem_we <= accept && imm_ok;

      if (accept && imm_ok) begin
        imem_addr  <= next_addr;
        imem_wdata <= enc;
        next_addr  <= next_addr + ADDR_ONE;
        if (next_addr == TOP) top_seen <= 1'b1;
      end
      if (accept && !imm_ok) err_imm   <= 1'b1;
      if (accept && in_last) last_seen <= 1'b1;

      if (imem_we) count <= count + CNT_ONE;

      if ((state_q == LOAD) && (state_d == DONE)) full <= top_seen;

      // Only reachable from IDLE/DONE, where no write is ever in flight.
      if (start_session) begin
        next_addr <= BASE;
        count     <= '0;
        err_imm   <= 1'b0;
        full      <= 1'b0;
        last_seen <= 1'b0;
        top_seen  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_inst_loader.sv
// Purpose     : checks rv32_inst_loader against a transaction-level model every cycle,
//               plus directed sessions pinned to hand-encoded instruction words.
// Latency     : model predicts the write one edge after each accepted bundle.
// Backpressure: the driver holds a bundle until in_ready, bounded by a cycle budget.
module tb_rv32_inst_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_kind = 2'd0;
  logic [4:0]    in_rd = 5'd0;
  logic [4:0]    in_rs1 = 5'd0;
  logic [4:0]    in_rs2 = 5'd0;
  logic [2:0]    in_funct3 = 3'd0;
  logic          in_f7b5 = 1'b0;
  logic [12:0]   in_imm = 13'd0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          full;
  logic          err_imm;
  logic [AW:0]   count;

  rv32_inst_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .full(full), .err_imm(err_imm), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] encode(input logic [1:0] k, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic f7, input logic [12:0] imm);
    logic [31:0] i, d, s1, s2;
    i  = {19'd0, imm};
    d  = {27'd0, rd};
    s1 = {27'd0, rs1};
    s2 = {27'd0, rs2};
    case (k)
      2'd0:    return ({31'd0, f7} << 30) | (s2 << 20) | (s1 << 15) |
                      ({29'd0, f3} << 12) | (d << 7) | 32'h33;
      2'd1:    return ((i & 32'hFFF) << 20) | (s1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
      2'd2:    return (((i >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) |
                      (32'd2 << 12) | ((i & 32'h1F) << 7) | 32'h23;
      default: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) |
                      (s2 << 20) | (s1 << 15) | (((i >> 1) & 32'hF) << 8) |
                      (((i >> 11) & 32'h1) << 7) | 32'h63;
    endcase
  endfunction

  function automatic bit legal(input logic [1:0] k, input logic [12:0] imm);
    int v;
    v = $signed(imm);
    if (k == 2'd1 || k == 2'd2) return (v >= -2048) && (v <= 2047);
    if (k == 2'd3) return (v % 2) == 0;
    return 1'b1;
  endfunction

  bit          model_ok = 1'b0;
  bit          m_idle, m_open, m_closing, m_done, m_we, m_err, m_full, m_top, m_can_start, m_nw;
  int          m_next, m_addr, m_count;
  logic [31:0] m_wdata;

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1'b1;
      m_idle = 1; m_open = 0; m_closing = 0; m_done = 0; m_we = 0;
      m_err = 0; m_full = 0; m_top = 0; m_next = 0; m_addr = 0; m_count = 0;
      m_wdata = 32'd0;
    end else if (model_ok) begin
      m_can_start = m_idle || m_done;
      m_nw = 1'b0;
      if (m_we) m_count++;
      if (m_closing) begin
        m_closing = 0;
        m_done    = 1;
        m_full    = m_top;
      end
      if (m_open && in_valid) begin
        if (legal(in_kind, in_imm)) begin
          m_nw    = 1'b1;
          m_addr  = m_next;
          m_wdata = encode(in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm);
          if (m_next == DEPTH - 1) begin
            m_top  = 1;
            m_open = 0;
          end
          m_next = (m_next + 1) % DEPTH;
        end else begin
          m_err = 1;
        end
        if (in_last) m_open = 0;
        if (!m_open) m_closing = 1;
      end
      if (start && m_can_start) begin
        m_idle = 0; m_done = 0; m_open = 1; m_next = 0;
        m_count = 0; m_err = 0; m_full = 0; m_top = 0;
      end
      m_we = m_nw;
    end
  end

  // ---------------- compare process + write monitor ----------------
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  always @(negedge clk) begin
    if (model_ok) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_open});
      chk("imem_we",  {31'd0, imem_we},  {31'd0, m_we});
      if (m_we) begin
        chk("imem_addr",  {{(32-AW){1'b0}}, imem_addr}, m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
      end
      chk("busy",    {31'd0, busy},    {31'd0, (m_open || m_closing || m_we)});
      chk("done",    {31'd0, done},    {31'd0, m_done});
      chk("full",    {31'd0, full},    {31'd0, m_full});
      chk("err_imm", {31'd0, err_imm}, {31'd0, m_err});
      chk("count",   {{(31-AW){1'b0}}, count}, m_count);
    end
    if (imem_we === 1'b1) begin
      wq_addr.push_back({{(32-AW){1'b0}}, imem_addr});
      wq_data.push_back(imem_wdata);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                      input logic [12:0] imm, input logic last, output bit acc);
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_f7b5 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) acc = 1'b1;
      tick();
    end
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic clear_wq();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic chk_write(input string nm, input int idx, input logic [31:0] a,
                           input logic [31:0] d);
    if (idx < wq_addr.size()) begin
      chk({nm, "_addr"}, wq_addr[idx], a);
      chk({nm, "_data"}, wq_data[idx], d);
    end else begin
      chk({nm, "_present"}, 32'(wq_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    bit acc;
    int n;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_we",    {31'd0, imem_we},  32'd0);
    chk("rst_addr",  {{(32-AW){1'b0}}, imem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", {{(31-AW){1'b0}}, count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    tick();
    rst = 1'b0;

    // Single R bundle marked last
    clear_wq();
    pulse_start();
    send(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 1'b1, acc);
    chk("single_acc", {31'd0, acc}, 32'd1);
    idle_in();
    @(negedge clk);
    chk("single_we",    {31'd0, imem_we}, 32'd1);
    chk("single_addr",  {{(32-AW){1'b0}}, imem_addr}, 32'd0);
    chk("single_wdata", imem_wdata, 32'h002081B3);
    tick();
    @(negedge clk);
    chk("single_done",  {31'd0, done}, 32'd1);
    chk("single_count", {{(31-AW){1'b0}}, count}, 32'd1);
    chk("single_ready", {31'd0, in_ready}, 32'd0);

    // Restart from DONE, then back-to-back stream
    tick();
    clear_wq();
    pulse_start();
    @(negedge clk);
    chk("restart_ready", {31'd0, in_ready}, 32'd1);
    chk("restart_count", {{(31-AW){1'b0}}, count}, 32'd0);
    chk("restart_err",   {31'd0, err_imm}, 32'd0);
    tick();
    send(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0,    1'b0, acc);
    send(2'd1, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 13'd8,    1'b0, acc);
    send(2'd2, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 13'd12,   1'b0, acc);
    send(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FFC, 1'b1, acc);
    idle_in();
    repeat (3) tick();
    chk("b2b_nwrites", 32'(wq_addr.size()), 32'd4);
    chk_write("b2b_w0", 0, 32'd0, 32'h402081B3);
    chk_write("b2b_w1", 1, 32'd1, 32'h00812283);
    chk_write("b2b_w2", 2, 32'd2, 32'h00512623);
    chk_write("b2b_w3", 3, 32'd3, 32'hFE208EE3);
    @(negedge clk);
    chk("b2b_count", {{(31-AW){1'b0}}, count}, 32'd4);
    chk("b2b_done",  {31'd0, done}, 32'd1);

    // Immediate rejection
    tick();
    clear_wq();
    pulse_start();
    send(2'd1, 5'd4, 5'd1, 5'd0, 3'd0, 1'b0, 13'd2048, 1'b0, acc);
    send(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd3,    1'b0, acc);
    send(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0,    1'b1, acc);
    idle_in();
    repeat (3) tick();
    chk("rej_nwrites", 32'(wq_addr.size()), 32'd1);
    chk_write("rej_w0", 0, 32'd0, 32'h002081B3);
    @(negedge clk);
    chk("rej_err",   {31'd0, err_imm}, 32'd1);
    chk("rej_count", {{(31-AW){1'b0}}, count}, 32'd1);

    // Full: five bundles offered, none marked last
    tick();
    clear_wq();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 5'(i + 1), 5'd1, 5'd2, 3'd7, 1'b0, 13'd0, 1'b0, acc);
      chk($sformatf("full_acc%0d", i), {31'd0, acc}, (i < 4) ? 32'd1 : 32'd0);
    end
    idle_in();
    repeat (2) tick();
    chk("full_nwrites", 32'(wq_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk_write($sformatf("full_w%0d", i), i, 32'(i),
                encode(2'd0, 5'(i + 1), 5'd1, 5'd2, 3'd7, 1'b0, 13'd0));
    @(negedge clk);
    chk("full_full",  {31'd0, full}, 32'd1);
    chk("full_done",  {31'd0, done}, 32'd1);
    chk("full_ready", {31'd0, in_ready}, 32'd0);

    // Reset in the cycle after a handshake
    tick();
    pulse_start();
    send(2'd0, 5'd9, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 1'b0, acc);
    rst = 1'b1;
    idle_in();
    tick();
    rst = 1'b0;
    n = wq_addr.size();
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
      tick();
    end
    chk("mid_rst_nwrites", 32'(wq_addr.size()), 32'(n));
    chk("mid_rst_count",   {{(31-AW){1'b0}}, count}, 32'd0);
    chk("mid_rst_ready",   {31'd0, in_ready}, 32'd0);
    chk("mid_rst_done",    {31'd0, done}, 32'd0);

    // Randomized traffic; the compare process checks every cycle
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 5) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_kind   = 2'($urandom_range(0, 3));
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_f7b5   = 1'($urandom);
      in_imm    = ($urandom_range(0, 1) == 0) ? 13'($urandom) : 13'($urandom_range(0, 64) * 2);
      in_last   = ($urandom_range(0, 4) == 0);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    idle_in();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
